idu_scoreboard: RTL and testbench

Decode-to-execute issue stage with a register scoreboard. It holds one decoded instruction in an output register and tracks outstanding GPR/CSR writes with per-register pending counters. An instruction issues to the EXU only when its sources are not pending and its destination counter is not saturated. This replaces per-stage rd/rs comparisons, so hazard detection is independent of pipeline depth. It sits between the IDU decode logic and the EXU; retire information comes from the WBU.

---
 rtl/idu_scoreboard.sv | 132 +++++++++++++
 tb/tb_idu_scoreboard.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/idu_scoreboard.sv
// idu_scoreboard: decode-to-execute issue stage with a per-register pending-write scoreboard
// Holds one decoded instruction and issues it to the EXU once its sources are not pending,
// its destination counter is not saturated and, for serializing instructions, nothing is pending.
// Ports: clk, rst_n (async active-low); in_* decoded instruction with valid/ready handshake;
// out_valid/out_ready/out_payload issue to EXU; wb_* retire from WBU; flush drops the held
// instruction; sb_idle (no writes pending); sb_err (sticky retire of a zero counter).
// Optional macro IDU_SB_BYPASS_EN: hazards see counters minus the same-cycle retire.
module idu_scoreboard #(
   parameter int NREG = 32,
   parameter int NCSR = 4,
   parameter int CNT_W = 2,
   parameter int PAYLOAD_W = 128,
   localparam int RW = $clog2(NREG),
   localparam int CW = $clog2(NCSR)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [RW-1:0]        in_rs1,
   input  logic [RW-1:0]        in_rs2,
   input  logic                 in_rs1_use,
   input  logic                 in_rs2_use,
   input  logic [RW-1:0]        in_rd,
   input  logic                 in_rd_we,
   input  logic [CW-1:0]        in_csr_rs,
   input  logic [CW-1:0]        in_csr_rd,
   input  logic                 in_csr_use,
   input  logic                 in_csr_we,
   input  logic                 in_serialize,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_payload,
   input  logic                 wb_valid,
   input  logic [RW-1:0]        wb_rd,
   input  logic                 wb_rd_we,
   input  logic [CW-1:0]        wb_csr_rd,
   input  logic                 wb_csr_we,
   input  logic                 flush,
   output logic                 sb_idle,
   output logic                 sb_err
);
   localparam logic [CNT_W-1:0] MAX = '1;
   logic held, rs1_use, rs2_use, rd_we, csr_use, csr_we, serialize;
   logic [RW-1:0] rs1, rs2, rd;
   logic [CW-1:0] csr_rs, csr_rd;
   logic [CNT_W-1:0] gcnt [NREG];
   logic [CNT_W-1:0] gnext [NREG];
   logic [CNT_W-1:0] geff [NREG];
   logic [CNT_W-1:0] ccnt [NCSR];
   logic [CNT_W-1:0] cnext [NCSR];
   logic [CNT_W-1:0] ceff [NCSR];
   logic hazard, issue, accept, g_ret, c_ret, g_bad, c_bad, idle_eff, idle_next;

   // x0 is never tracked, so a retire naming x0 is not a retire at all
   assign g_ret = wb_valid && wb_rd_we && wb_rd != '0;
   assign c_ret = wb_valid && wb_csr_we;
   assign g_bad = g_ret && gcnt[wb_rd] == '0;
   assign c_bad = c_ret && ccnt[wb_csr_rd] == '0;

   // counters as seen by hazard evaluation; with bypass the same-cycle retire is already freed
   always_comb begin
      idle_eff = 1'b1;
      for (int i = 0; i < NREG; i++) begin
`ifdef IDU_SB_BYPASS_EN
         geff[i] = gcnt[i] - CNT_W'(g_ret && wb_rd == RW'(i) && gcnt[i] != '0);
`else
         geff[i] = gcnt[i];
`endif
         idle_eff = idle_eff && geff[i] == '0;
      end
      for (int i = 0; i < NCSR; i++) begin
`ifdef IDU_SB_BYPASS_EN
         ceff[i] = ccnt[i] - CNT_W'(c_ret && wb_csr_rd == CW'(i) && ccnt[i] != '0);
`else
         ceff[i] = ccnt[i];
`endif
         idle_eff = idle_eff && ceff[i] == '0;
      end
   end

   assign hazard = (rs1_use && rs1 != '0 && geff[rs1] != '0)
                || (rs2_use && rs2 != '0 && geff[rs2] != '0)
                || (csr_use && ceff[csr_rs] != '0)
                || (rd_we && rd != '0 && geff[rd] == MAX)
                || (csr_we && ceff[csr_rd] == MAX)
                || (serialize && !idle_eff);
   assign out_valid = held && !hazard && !flush;
   assign issue = out_valid && out_ready;
   assign in_ready = !flush && (!held || issue);
   assign accept = in_valid && in_ready;

   // a retire of a zero counter is dropped; issue and retire to one counter cancel out
   always_comb begin
      idle_next = 1'b1;
      for (int i = 0; i < NREG; i++) begin
         gnext[i] = gcnt[i] + CNT_W'(issue && rd_we && rd != '0 && rd == RW'(i))
                  - CNT_W'(g_ret && wb_rd == RW'(i) && gcnt[i] != '0);
         idle_next = idle_next && gnext[i] == '0;
      end
      for (int i = 0; i < NCSR; i++) begin
         cnext[i] = ccnt[i] + CNT_W'(issue && csr_we && csr_rd == CW'(i))
                  - CNT_W'(c_ret && wb_csr_rd == CW'(i) && ccnt[i] != '0);
         idle_next = idle_next && cnext[i] == '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held <= 1'b0;
         gcnt <= '{default: '0};
         ccnt <= '{default: '0};
         sb_idle <= 1'b1;
         sb_err <= 1'b0;
         {rs1, rs2, rd, rs1_use, rs2_use, rd_we} <= '0;
         {csr_rs, csr_rd, csr_use, csr_we, serialize} <= '0;
         out_payload <= '0;
      end else begin
         held <= !flush && (accept || (held && !issue));
         gcnt <= gnext;
         ccnt <= cnext;
         sb_idle <= idle_next;
         sb_err <= sb_err || g_bad || c_bad;
         if (accept) begin
            {rs1, rs2, rd, rs1_use, rs2_use, rd_we} <= {in_rs1, in_rs2, in_rd, in_rs1_use, in_rs2_use, in_rd_we};
            {csr_rs, csr_rd, csr_use, csr_we, serialize} <= {in_csr_rs, in_csr_rd, in_csr_use, in_csr_we, in_serialize};
            out_payload <= in_payload;
         end
      end
   end
endmodule

// File: tb/tb_idu_scoreboard.sv
// tb_idu_scoreboard: directed and random stimulus for idu_scoreboard against a count-based model;
// issued payloads are queued when predicted and checked by a separate monitor on each DUT issue.
module tb_idu_scoreboard;
   localparam int MAXC = 3;
   typedef struct packed {
      logic [4:0] rs1, rs2, rd;
      logic rs1_use, rs2_use, rd_we;
      logic [1:0] csr_rs, csr_rd;
      logic csr_use, csr_we, ser;
      logic [127:0] pay;
   } ins_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid, in_ready, in_rs1_use, in_rs2_use, in_rd_we, in_csr_use, in_csr_we, in_serialize;
   logic [4:0] in_rs1, in_rs2, in_rd, wb_rd;
   logic [1:0] in_csr_rs, in_csr_rd, wb_csr_rd;
   logic [127:0] in_payload, out_payload;
   logic out_valid, out_ready, wb_valid, wb_rd_we, wb_csr_we, flush, sb_idle, sb_err;

   idu_scoreboard dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_use(in_rs1_use), .in_rs2_use(in_rs2_use),
      .in_rd(in_rd), .in_rd_we(in_rd_we), .in_csr_rs(in_csr_rs), .in_csr_rd(in_csr_rd),
      .in_csr_use(in_csr_use), .in_csr_we(in_csr_we), .in_serialize(in_serialize),
      .in_payload(in_payload), .out_valid(out_valid), .out_ready(out_ready),
      .out_payload(out_payload), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_we(wb_rd_we),
      .wb_csr_rd(wb_csr_rd), .wb_csr_we(wb_csr_we), .flush(flush), .sb_idle(sb_idle),
      .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   logic [127:0] exp_q[$];
   int pend_g[$], pend_c[$];
   int gc[32], cc[4];
   bit m_held, m_err;
   ins_t m_ins;
   bit d_valid, d_ready, d_wbv, d_wbrwe, d_wbcwe, d_flush;
   logic [4:0] d_wbrd;
   logic [1:0] d_wbc;
   ins_t d_ins;

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   function automatic ins_t mk(int r1, bit u1, int r2, bit u2, int rd, bit we, bit ser);
      ins_t x = '0;
      x.rs1 = 5'(r1); x.rs1_use = u1; x.rs2 = 5'(r2); x.rs2_use = u2;
      x.rd = 5'(rd); x.rd_we = we; x.ser = ser;
      x.pay = {$urandom, $urandom, $urandom, $urandom};
      return x;
   endfunction

   function automatic ins_t rnd_ins();
      ins_t x = mk($urandom_range(7, 0), $urandom_range(99, 0) < 70, $urandom_range(7, 0),
                   $urandom_range(99, 0) < 70, $urandom_range(7, 0), $urandom_range(99, 0) < 60,
                   $urandom_range(99, 0) < 5);
      x.csr_rs = 2'($urandom_range(3, 0)); x.csr_use = $urandom_range(99, 0) < 20;
      x.csr_rd = 2'($urandom_range(3, 0)); x.csr_we = $urandom_range(99, 0) < 15;
      return x;
   endfunction

   task automatic clr();
      d_valid = 0; d_ready = 0; d_wbv = 0; d_wbrwe = 0; d_wbcwe = 0; d_flush = 0;
      d_wbrd = '0; d_wbc = '0; d_ins = '0;
   endtask

   task automatic m_reset();
      m_held = 0; m_err = 0; m_ins = '0;
      foreach (gc[i]) gc[i] = 0;
      foreach (cc[i]) cc[i] = 0;
      pend_g.delete(); pend_c.delete(); exp_q.delete();
   endtask

   // one clock: drive after the falling edge, check before the rising edge, then advance the model
   task automatic step();
      int tot;
      bit hz, ov, iss, rdy, acc;
      in_valid = d_valid; in_rs1 = d_ins.rs1; in_rs2 = d_ins.rs2; in_rs1_use = d_ins.rs1_use;
      in_rs2_use = d_ins.rs2_use; in_rd = d_ins.rd; in_rd_we = d_ins.rd_we;
      in_csr_rs = d_ins.csr_rs; in_csr_rd = d_ins.csr_rd; in_csr_use = d_ins.csr_use;
      in_csr_we = d_ins.csr_we; in_serialize = d_ins.ser; in_payload = d_ins.pay;
      out_ready = d_ready; wb_valid = d_wbv; wb_rd = d_wbrd; wb_rd_we = d_wbrwe;
      wb_csr_rd = d_wbc; wb_csr_we = d_wbcwe; flush = d_flush;
      #2;
      tot = 0;
      foreach (gc[i]) tot += gc[i];
      foreach (cc[i]) tot += cc[i];
      hz = (m_ins.rs1_use && m_ins.rs1 != 0 && gc[m_ins.rs1] > 0)
        || (m_ins.rs2_use && m_ins.rs2 != 0 && gc[m_ins.rs2] > 0)
        || (m_ins.csr_use && cc[m_ins.csr_rs] > 0)
        || (m_ins.rd_we && m_ins.rd != 0 && gc[m_ins.rd] == MAXC)
        || (m_ins.csr_we && cc[m_ins.csr_rd] == MAXC)
        || (m_ins.ser && tot != 0);
      ov = m_held && !hz && !d_flush;
      iss = ov && d_ready;
      rdy = !d_flush && (!m_held || iss);
      acc = d_valid && rdy;
      chk("out_valid", out_valid, ov);
      chk("in_ready", in_ready, rdy);
      chk("sb_idle", sb_idle, tot == 0);
      chk("sb_err", sb_err, m_err);
      if (m_held) chk("out_payload", out_payload, m_ins.pay);
      if (iss) exp_q.push_back(m_ins.pay);
      @(posedge clk);
      if (d_wbv && d_wbrwe && d_wbrd != 0) begin
         if (gc[d_wbrd] == 0) m_err = 1; else gc[d_wbrd]--;
      end
      if (d_wbv && d_wbcwe) begin
         if (cc[d_wbc] == 0) m_err = 1; else cc[d_wbc]--;
      end
      if (iss && m_ins.rd_we && m_ins.rd != 0) begin gc[m_ins.rd]++; pend_g.push_back(m_ins.rd); end
      if (iss && m_ins.csr_we) begin cc[m_ins.csr_rd]++; pend_c.push_back(m_ins.csr_rd); end
      m_held = d_flush ? 0 : acc ? 1 : iss ? 0 : m_held;
      if (acc) m_ins = d_ins;
      @(negedge clk);
   endtask

   task automatic ret_g(int r);
      clr(); d_ready = 1; d_wbv = 1; d_wbrwe = 1; d_wbrd = 5'(r); step();
   endtask

   // monitor: every DUT issue must match the oldest predicted issue
   always begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_issue", 1'b1, 1'b0);
         else chk("issue_payload", out_payload, exp_q.pop_front());
      end
   end

   initial begin
      m_reset(); clr();
      in_valid = 0; out_ready = 0; wb_valid = 0; flush = 0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_sb_idle", sb_idle, 1);
      chk("rst_sb_err", sb_err, 0);
      chk("rst_payload", out_payload, 0);
      rst_n = 1;
      // add x3,x1,x2 with clean sources
      clr(); d_valid = 1; d_ins = mk(1, 1, 2, 1, 3, 1, 0); d_ready = 1; step();
      chk("add_ready", out_valid, 1);
      clr(); d_ready = 1; step();
      chk("add_pending", sb_idle, 0);
      ret_g(3);
      // RAW on x5 releases the cycle after retire
      clr(); d_valid = 1; d_ins = mk(0, 0, 0, 0, 5, 1, 0); d_ready = 1; step();
      clr(); d_valid = 1; d_ins = mk(5, 1, 0, 0, 6, 0, 0); d_ready = 1; step();
      repeat (3) begin clr(); d_ready = 1; step(); end
      chk("raw_stall", out_valid, 0);
      ret_g(5);
      clr(); d_ready = 1; step();
      // saturation on x7
      repeat (4) begin clr(); d_valid = 1; d_ins = mk(0, 0, 0, 0, 7, 1, 0); d_ready = 1; step(); end
      repeat (3) begin clr(); d_ready = 1; step(); end
      chk("sat_stall", out_valid, 0);
      ret_g(7);
      clr(); d_ready = 1; step();
      // serializing instruction waits for an empty scoreboard
      clr(); d_valid = 1; d_ins = mk(0, 0, 0, 0, 0, 0, 1); d_ready = 1;
      d_wbv = 1; d_wbrwe = 1; d_wbrd = 7; step();
      repeat (2) begin clr(); d_ready = 1; step(); end
      ret_g(7);
      clr(); d_ready = 1; step();
      chk("ser_stall", out_valid, 0);
      ret_g(7);
      clr(); d_ready = 1; step();
      // flush a stalled reader, then x0 never stalls while x4 is pending
      clr(); d_valid = 1; d_ins = mk(0, 0, 0, 0, 4, 1, 0); d_ready = 1; step();
      clr(); d_valid = 1; d_ins = mk(4, 1, 4, 1, 2, 1, 0); d_ready = 1; step();
      repeat (2) begin clr(); d_ready = 1; step(); end
      clr(); d_ready = 1; d_flush = 1; d_valid = 1; d_ins = mk(0, 0, 0, 0, 1, 1, 0); step();
      clr(); step();
      clr(); d_valid = 1; d_ins = mk(0, 1, 0, 1, 0, 1, 0); step();
      chk("x0_nostall", out_valid, 1);
      clr(); d_ready = 1; step();
      ret_g(4);
      clr(); step();
      // random traffic from a clean state
      rst_n = 0; #1; m_reset(); @(negedge clk); rst_n = 1;
      for (int n = 0; n < 3000; n++) begin
         clr();
         d_valid = $urandom_range(99, 0) < 70;
         d_ins = rnd_ins();
         d_ready = $urandom_range(99, 0) < 75;
         d_flush = $urandom_range(99, 0) < 4;
         if (pend_g.size() > 0 && $urandom_range(99, 0) < 45) begin
            int k = $urandom_range(pend_g.size() - 1, 0);
            d_wbv = 1; d_wbrwe = 1; d_wbrd = 5'(pend_g[k]); pend_g.delete(k);
         end
         if (pend_c.size() > 0 && $urandom_range(99, 0) < 45) begin
            int k = $urandom_range(pend_c.size() - 1, 0);
            d_wbv = 1; d_wbcwe = 1; d_wbc = 2'(pend_c[k]); pend_c.delete(k);
         end
         step();
      end
      // asynchronous reset mid-operation
      #1 rst_n = 0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_sb_idle", sb_idle, 1);
      m_reset();
      @(negedge clk); rst_n = 1;
      // stale retire after reset
      ret_g(9);
      chk("spurious_err", sb_err, 1);
      repeat (3) begin clr(); step(); end
      chk("err_sticky", sb_err, 1);
      chk("exp_q_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
